// File: rtl/riscv_alu_tag_pipe_pkg.sv
// Shared tag-ALU definitions: propagation mode encodings from the Tag Propagation Register.
package riscv_alu_tag_pipe_pkg;

  localparam int unsigned ALU_MODE_WIDTH = 3;

  // Original encodings keep their values; XOR and SET take the next free codes, 6 and 7 stay undefined.
  typedef enum logic [ALU_MODE_WIDTH-1:0] {
    ALU_MODE_OLD   = 3'd0,
    ALU_MODE_AND   = 3'd1,
    ALU_MODE_OR    = 3'd2,
    ALU_MODE_CLEAR = 3'd3,
    ALU_MODE_XOR   = 3'd4,
    ALU_MODE_SET   = 3'd5
  } alu_mode_e;

endpackage

// File: rtl/riscv_alu_tag_pipe_policy.sv
// Combinational tag propagation and tag-check policy: maps mode and source tags to the
// destination tag, write enables and a violation indication.
module riscv_tag_policy
  import riscv_alu_tag_pipe_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic [ALU_MODE_WIDTH-1:0] operator_i,
  input  logic [TAG_WIDTH-1:0]      operand_a_i,
  input  logic [TAG_WIDTH-1:0]      operand_b_i,
  input  logic                      check_en_i,
  input  logic [TAG_WIDTH-1:0]      check_mask_i,
  output logic [TAG_WIDTH-1:0]      result_o,
  output logic                      rf_enable_o,
  output logic                      pc_enable_o,
  output logic                      viol_o
);

  logic active;

  always_comb begin
    result_o = '0;
    active   = 1'b1;
    case (operator_i)
      ALU_MODE_AND:   result_o = operand_a_i & operand_b_i;
      ALU_MODE_OR:    result_o = operand_a_i | operand_b_i;
      ALU_MODE_XOR:   result_o = operand_a_i ^ operand_b_i;
      ALU_MODE_CLEAR: result_o = '0;
      ALU_MODE_SET:   result_o = '1;
      // OLD and every undefined code: no propagation, no write-back, never a violation.
      default:        active   = 1'b0;
    endcase
  end

  assign rf_enable_o = active;
  assign pc_enable_o = active;
  assign viol_o      = active & check_en_i & (|(result_o & check_mask_i));

endmodule

// File: rtl/riscv_alu_tag_pipe.sv
// EX-stage tag ALU: one registered output stage with stall hold, plus a sticky violation
// flag and a saturating violation counter.
module riscv_alu_tag_pipe
  import riscv_alu_tag_pipe_pkg::*;
#(
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned VIOL_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en_i,
  input  logic                      stall_i,
  input  logic [ALU_MODE_WIDTH-1:0] operator_i,
  input  logic [TAG_WIDTH-1:0]      operand_a_i,
  input  logic [TAG_WIDTH-1:0]      operand_b_i,
  input  logic                      check_en_i,
  input  logic [TAG_WIDTH-1:0]      check_mask_i,
  input  logic                      clear_viol_i,
  output logic                      valid_o,
  output logic [TAG_WIDTH-1:0]      result_o,
  output logic                      rf_enable_tag_o,
  output logic                      pc_enable_tag_o,
  output logic                      violation_o,
  output logic                      viol_sticky_o,
  output logic [VIOL_CNT_WIDTH-1:0] viol_count_o
);

  logic [TAG_WIDTH-1:0]      res_c;
  logic                      rf_en_c, pc_en_c, viol_c;
  logic                      accept, accept_viol;

  logic                      valid_q, valid_d;
  logic [TAG_WIDTH-1:0]      result_q, result_d;
  logic                      rf_en_q, rf_en_d;
  logic                      pc_en_q, pc_en_d;
  logic                      viol_q, viol_d;
  logic                      sticky_q, sticky_d;
  logic [VIOL_CNT_WIDTH-1:0] count_q, count_d;

  riscv_tag_policy #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_policy (
    .operator_i   (operator_i),
    .operand_a_i  (operand_a_i),
    .operand_b_i  (operand_b_i),
    .check_en_i   (check_en_i),
    .check_mask_i (check_mask_i),
    .result_o     (res_c),
    .rf_enable_o  (rf_en_c),
    .pc_enable_o  (pc_en_c),
    .viol_o       (viol_c)
  );

  assign accept      = en_i & ~stall_i;
  assign accept_viol = accept & viol_c;

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rf_en_d  = rf_en_q;
    pc_en_d  = pc_en_q;
    viol_d   = viol_q;
    sticky_d = sticky_q;
    count_d  = count_q;

    if (!stall_i) begin
      valid_d = en_i;
      rf_en_d = en_i & rf_en_c;
      pc_en_d = en_i & pc_en_c;
      viol_d  = en_i & viol_c;
      if (en_i) result_d = res_c;
    end

    // A violation accepted in the same cycle as a clear survives it as the first new count.
    if (accept_viol) begin
      sticky_d = 1'b1;
      if (clear_viol_i)      count_d = VIOL_CNT_WIDTH'(1);
      else if (count_q != '1) count_d = count_q + 1'b1;
    end else if (clear_viol_i) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rf_en_q  <= 1'b0;
      pc_en_q  <= 1'b0;
      viol_q   <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rf_en_q  <= rf_en_d;
      pc_en_q  <= pc_en_d;
      viol_q   <= viol_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign valid_o         = valid_q;
  assign result_o        = result_q;
  assign rf_enable_tag_o = rf_en_q;
  assign pc_enable_tag_o = pc_en_q;
  assign violation_o     = viol_q;
  assign viol_sticky_o   = sticky_q;
  assign viol_count_o    = count_q;

endmodule

// File: doc/riscv_alu_tag_pipe.md
# riscv_alu_tag_pipe

Parametrised, pipelined successor of the single-bit tag ALU in the RI5CY DIFT datapath. Computes a TAG_WIDTH-bit destination tag from two source tags under the mode selected by the Tag Propagation Register. Registers the result in one stage with stall support. Adds a tag-check policy with a per-operation violation pulse, a sticky violation flag and a saturating violation counter. Sits in the EX stage beside the data ALU; its outputs feed the tag register-file write port and the PC-tag update.

## Interface
- TAG_WIDTH, 4, width of each tag
- VIOL_CNT_WIDTH, 8, width of the violation counter
- clk  in  1  clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- en_i  in  1  valid tag operation presented this cycle
- stall_i  in  1  downstream stall; holds the output stage
- operator_i  in  ALU_MODE_WIDTH  propagation mode from the Tag Propagation Register
- operand_a_i  in  TAG_WIDTH  source tag A
- operand_b_i  in  TAG_WIDTH  source tag B
- check_en_i  in  1  enables the tag check
- check_mask_i  in  TAG_WIDTH  tag bits that raise a violation
- clear_viol_i  in  1  clears the sticky flag and the counter
- valid_o  out  1  registered result valid
- result_o  out  TAG_WIDTH  registered destination tag
- rf_enable_tag_o  out  1  write the result to the tag register file
- pc_enable_tag_o  out  1  update the PC tag
- violation_o  out  1  the registered operation violated the check mask
- viol_sticky_o  out  1  a violation occurred since the last clear or reset
- viol_count_o  out  VIOL_CNT_WIDTH  number of violations, saturating

## Operation
- Accept: accept = en_i & ~stall_i.
- Mode functions, applied per bit to the full TAG_WIDTH:
  - ALU_MODE_OLD: result 0; rf_enable 0; pc_enable 0.
  - ALU_MODE_AND: a & b.
  - ALU_MODE_OR: a | b.
  - ALU_MODE_XOR: a ^ b.
  - ALU_MODE_CLEAR: all zeros.
  - ALU_MODE_SET: all ones.
- For every mode except OLD, rf_enable and pc_enable are both 1.
- An undefined encoding behaves as OLD and raises no violation. There are no X outputs in any mode.
- Violation: viol = check_en_i & |(result & check_mask_i). It is evaluated on the combinational result. It is forced to 0 in OLD mode or for an undefined encoding.
- On accept, the output stage loads:
  - valid_o = 1
  - result_o
  - rf_enable_tag_o
  - pc_enable_tag_o
  - violation_o = viol
- If stall_i = 1, every output-stage register holds its value, including valid_o and violation_o.
- If stall_i = 0 and en_i = 0, the stage loads valid_o = 0, violation_o = 0, rf_enable_tag_o = 0 and pc_enable_tag_o = 0; result_o holds.
- Counter, evaluated at the same edge as the accept:
  - accept & viol & ~clear_viol_i: sticky = 1; count = count + 1, saturating at 2^VIOL_CNT_WIDTH − 1.
  - clear_viol_i & ~(accept & viol): sticky = 0; count = 0.
  - clear_viol_i & accept & viol: sticky = 1; count = 1. The new violation survives the clear.
  - clear_viol_i acts even while stall_i = 1. A stalled cycle never counts.

## Timing
- Latency: 1 cycle from accept to valid_o and result_o.
- Throughput: one operation per cycle when not stalled.
- viol_count_o and viol_sticky_o update at the same edge that raises valid_o for the violating operation.
- stall_i has no combinational path to any output. It only gates the register enables.
- Reset, with rst_n sampled low at a clock edge: every output goes to 0, including result_o, valid_o, the counter and the sticky flag.
- Reset dominates en_i, stall_i and clear_viol_i. An operation in flight when reset is asserted is dropped, not completed.
- Saturation: at the maximum count a further violation leaves the count at the maximum and viol_sticky_o at 1.

## Structure
- Add to riscv_defines:
  - new encodings ALU_MODE_XOR and ALU_MODE_SET, distinct from the existing ALU_MODE_OLD, AND, OR and CLEAR;
  - ALU_MODE_WIDTH widened if the new encodings require it.
- Sub-module riscv_tag_policy: purely combinational. Maps operator, a, b, check_en and mask to result, rf_enable, pc_enable and viol.
- The top level holds the output-stage registers and the violation counter.

## Test plan
- Mode sweep, TAG_WIDTH = 4, a = 4'b1100, b = 4'b1010, each held for one accept:
  - AND → 1000
  - OR → 1110
  - XOR → 0110
  - CLEAR → 0000
  - SET → 1111
  - OLD → 0000 with both enables 0
  - all results appear one cycle later with valid_o = 1.
- Stall: accept OR(0001, 0010), then assert stall_i for 3 cycles with a new en_i → result_o stays 0011 and valid_o stays 1, with no new capture. After release, the pending input is captured on the next edge.
- Check: check_en_i = 1, mask = 1000.
  - SET → violation_o = 1, count 1, sticky 1.
  - AND(0111, 1111) → violation_o = 0, count stays 1.
- Saturation: VIOL_CNT_WIDTH = 2, five violating accepts → count 1, 2, 3, 3, 3; sticky 1 throughout.
- Clear collision: count = 2, then clear_viol_i with a violating accept in the same cycle → count 1, sticky 1. Next cycle, clear alone → count 0, sticky 0.
- Reset mid-operation: rst_n low for one edge with en_i = 1 and SET → all outputs 0 after the edge, with no violation counted.
